// File: rtl/iob_plic_irq_cond.sv
// Interrupt source conditioner placed directly upstream of the PLIC `src` vector.
// Each raw line is polarity-normalised, synchronised, debounced and then presented
// either as a clean level or as a one-cycle pulse per rising edge.
//
// Ports:
//   clk_i       system clock, all state on the rising edge
//   rst_n_i     synchronous active-low reset, overrides cke_i
//   cke_i       clock enable, 0 holds every register
//   irq_i       raw asynchronous interrupt lines
//   pol_i       1 = source is active-low (applied before the synchroniser)
//   el_i        1 = edge mode (pulse), 0 = level mode
//   en_i        per-source output enable
//   debounce_i  stability threshold in enabled cycles (0 and 1 = no filtering)
//   src_o       registered conditioned requests to the PLIC
//   filt_o      debounced level per source (status)
module iob_plic_irq_cond #(
    parameter int unsigned SOURCES     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cke_i,
    input  logic [SOURCES-1:0]    irq_i,
    input  logic [SOURCES-1:0]    pol_i,
    input  logic [SOURCES-1:0]    el_i,
    input  logic [SOURCES-1:0]    en_i,
    input  logic [DEBOUNCE_W-1:0] debounce_i,
    output logic [SOURCES-1:0]    src_o,
    output logic [SOURCES-1:0]    filt_o
);

    // Counter compare is done one bit wider so cnt + 1 never wraps.
    localparam int unsigned CMP_W = DEBOUNCE_W + 1;

    // Stage 0 samples the normalised line; stage SYNC_STAGES-1 is the synchronised value.
    logic [SYNC_STAGES-1:0][SOURCES-1:0]    sync_q;
    logic [SOURCES-1:0]                     filt_q;
    logic [SOURCES-1:0]                     filt_d_q;
    logic [SOURCES-1:0]                     src_q;
    logic [SOURCES-1:0][DEBOUNCE_W-1:0]     cnt_q;

    logic [SOURCES-1:0]                     line;
    logic [SOURCES-1:0]                     sync_s;
    logic                                   no_filter;
    logic [SOURCES-1:0]                     filt_n;
    logic [SOURCES-1:0][DEBOUNCE_W-1:0]     cnt_n;
    logic [SOURCES-1:0]                     src_n;

    assign line      = irq_i ^ pol_i;
    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign no_filter = (debounce_i <= DEBOUNCE_W'(1));

    // Debounce: filt follows sync_s only after D consecutive differing cycles.
    always_comb begin
        filt_n = filt_q;
        cnt_n  = cnt_q;
        for (int unsigned i = 0; i < SOURCES; i++) begin
            if (sync_s[i] == filt_q[i]) begin
                cnt_n[i] = '0;
            end else if (no_filter ||
                         ((CMP_W'(cnt_q[i]) + CMP_W'(1)) >= CMP_W'(debounce_i))) begin
                // >= lets a threshold lowered mid-count commit on the next differing cycle
                filt_n[i] = sync_s[i];
                cnt_n[i]  = '0;
            end else begin
                cnt_n[i] = cnt_q[i] + DEBOUNCE_W'(1);
            end
        end
    end

    // Edge lanes see only the 0->1 transition of filt; level lanes see filt itself.
    always_comb begin
        src_n = en_i & ((el_i & filt_q & ~filt_d_q) | (~el_i & filt_q));
    end

    // State registers; reset wins over the clock enable.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q   <= '0;
            filt_q   <= '0;
            filt_d_q <= '0;
            cnt_q    <= '0;
            src_q    <= '0;
        end else if (cke_i) begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], line};
            filt_q   <= filt_n;
            filt_d_q <= filt_q;
            cnt_q    <= cnt_n;
            src_q    <= src_n;
        end
    end

    assign src_o  = src_q;
    assign filt_o = filt_q;

endmodule

// File: tb/tb_iob_plic_irq_cond.sv
// Self-checking bench for iob_plic_irq_cond: directed scenarios with fixed
// expected timing plus randomized traffic against a behavioural model.
module tb_iob_plic_irq_cond;

    localparam int unsigned SOURCES     = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DEBOUNCE_W  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cke;
    logic [SOURCES-1:0]    irq;
    logic [SOURCES-1:0]    pol;
    logic [SOURCES-1:0]    el;
    logic [SOURCES-1:0]    en;
    logic [DEBOUNCE_W-1:0] debounce;
    logic [SOURCES-1:0]    src_o;
    logic [SOURCES-1:0]    filt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: delay line of normalised vectors, run length of
    // consecutive cycles the synchronised value disagrees with the filtered one.
    logic [SOURCES-1:0] m_pipe[$];
    logic [SOURCES-1:0] m_filt   = '0;
    logic [SOURCES-1:0] m_prev   = '0;
    logic [SOURCES-1:0] m_src    = '0;
    int                 m_run[SOURCES];

    iob_plic_irq_cond #(
        .SOURCES(SOURCES), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .irq_i(irq), .pol_i(pol),
        .el_i(el), .en_i(en), .debounce_i(debounce), .src_o(src_o), .filt_o(filt_o)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic step();
        logic [SOURCES-1:0] s, nf;
        int thr;
        if (!rst_n) begin
            m_pipe = {};
            for (int k = 0; k < int'(SYNC_STAGES); k++) m_pipe.push_back('0);
            m_filt = '0; m_prev = '0; m_src = '0;
            for (int k = 0; k < int'(SOURCES); k++) m_run[k] = 0;
        end else if (cke) begin
            s = m_pipe.pop_front();
            m_pipe.push_back(irq ^ pol);
            thr = (int'(debounce) <= 1) ? 1 : int'(debounce);
            nf = m_filt;
            for (int k = 0; k < int'(SOURCES); k++) begin
                if (s[k] == m_filt[k]) m_run[k] = 0;
                else begin
                    m_run[k]++;
                    if (m_run[k] >= thr) begin nf[k] = s[k]; m_run[k] = 0; end
                end
            end
            for (int k = 0; k < int'(SOURCES); k++)
                m_src[k] = en[k] && (el[k] ? (m_filt[k] && !m_prev[k]) : m_filt[k]);
            m_prev = m_filt;
            m_filt = nf;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cke = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        irq = 8'hA5; pol = '0; el = '0; en = '1; debounce = 4'd3;
        rst_n = 1'b0; cke = 1'b1;
        step(); step();
        n_checks++;
        if (src_o !== 8'h00) begin n_errors++; $display("FAIL reset_src got=%h exp=00", src_o); end
        n_checks++;
        if (filt_o !== 8'h00) begin n_errors++; $display("FAIL reset_filt got=%h exp=00", filt_o); end
        irq = '0;
        rst_n = 1'b1;
        for (int e = 0; e < 6; e++) step();
    endtask

    task automatic test_level_path();
        int lat;
        do_reset();
        el = '0; en = '1; debounce = 4'd3; irq = 8'h04;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (filt_o[2] !== (e >= 5)) begin
                n_errors++; $display("FAIL level_filt edge=%0d got=%b exp=%b", e, filt_o[2], e >= 5);
            end
            n_checks++;
            if (src_o[2] !== (e >= 6)) begin
                n_errors++; $display("FAIL level_src edge=%0d got=%b exp=%b", e, src_o[2], e >= 6);
            end
        end
        irq = 8'h00;
        lat = -1;
        for (int e = 1; e <= 20 && lat < 0; e++) begin
            step();
            if (src_o[2] === 1'b0) lat = e;
        end
        n_checks++;
        if (lat != 6) begin n_errors++; $display("FAIL level_deassert_latency got=%0d exp=6", lat); end
    endtask

    task automatic test_glitch();
        int highs;
        logic seen;
        do_reset();
        el = '0; en = '1; debounce = 4'd3; irq = '0;
        seen = 1'b0;
        for (int e = 0; e < 16; e++) begin
            irq[0] = (e < 2) || (e >= 5 && e < 7);
            step();
            if (filt_o[0] !== 1'b0 || src_o[0] !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_errors++; $display("FAIL glitch_reject got=passed exp=blocked"); end
        debounce = 4'd0;
        highs = 0;
        for (int e = 0; e < 10; e++) begin
            irq[0] = (e == 0);
            step();
            if (src_o[0] === 1'b1) highs++;
        end
        n_checks++;
        if (highs != 1) begin n_errors++; $display("FAIL glitch_d0_pulse got=%0d exp=1", highs); end
    endtask

    task automatic test_edge_mode();
        int pulses, rise1, rise2;
        logic any;
        do_reset();
        el = 8'h20; en = '1; debounce = 4'd2; irq = 8'h20;
        pulses = 0; rise1 = -1; rise2 = -1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (src_o[5] === 1'b1) begin pulses++; if (rise1 < 0) rise1 = e; end
        end
        irq = 8'h00;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (src_o[5] === 1'b1) pulses++;
        end
        irq = 8'h20;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (src_o[5] === 1'b1) begin pulses++; if (rise2 < 0) rise2 = e; end
        end
        n_checks++;
        if (pulses != 2) begin n_errors++; $display("FAIL edge_pulse_count got=%0d exp=2", pulses); end
        n_checks++;
        if (rise1 != int'(SYNC_STAGES) + 3) begin
            n_errors++; $display("FAIL edge_first_latency got=%0d exp=%0d", rise1, SYNC_STAGES + 3);
        end
        n_checks++;
        if (rise2 != int'(SYNC_STAGES) + 3) begin
            n_errors++; $display("FAIL edge_second_latency got=%0d exp=%0d", rise2, SYNC_STAGES + 3);
        end
        // Re-enabling while the filtered level is already high must not pulse.
        en[5] = 1'b0;
        for (int e = 0; e < 3; e++) step();
        en[5] = 1'b1;
        any = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (src_o[5] !== 1'b0) any = 1'b1;
        end
        n_checks++;
        if (any) begin n_errors++; $display("FAIL edge_enable_no_pulse got=pulse exp=none"); end
    endtask

    task automatic test_polarity();
        int lat;
        logic any;
        do_reset();
        el = '0; en = '1; debounce = 4'd3; irq = '0;
        en[7] = 1'b0; pol[7] = 1'b1; irq[7] = 1'b1;
        for (int e = 0; e < 4; e++) step();
        en[7] = 1'b1;
        any = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            if (src_o[7] !== 1'b0) any = 1'b1;
        end
        n_checks++;
        if (any) begin n_errors++; $display("FAIL pol_idle got=1 exp=0"); end
        irq[7] = 1'b0;
        lat = -1;
        for (int e = 1; e <= 20 && lat < 0; e++) begin
            step();
            if (src_o[7] === 1'b1) lat = e;
        end
        n_checks++;
        if (lat != 6) begin n_errors++; $display("FAIL pol_assert_latency got=%0d exp=6", lat); end
        pol = '0; irq = '0;
        for (int e = 0; e < 8; e++) step();
    endtask

    task automatic test_cke_reset();
        logic frozen_bad;
        do_reset();
        el = '0; en = '1; debounce = 4'd3; irq = 8'h02;
        step(); step(); step();             // counter now at 1
        cke = 1'b0;
        frozen_bad = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (filt_o !== 8'h00 || src_o !== 8'h00) frozen_bad = 1'b1;
        end
        n_checks++;
        if (frozen_bad) begin n_errors++; $display("FAIL cke_frozen got=changed exp=held"); end
        cke = 1'b1;
        step();
        n_checks++;
        if (filt_o[1] !== 1'b0) begin n_errors++; $display("FAIL cke_resume1 got=%b exp=0", filt_o[1]); end
        step();
        n_checks++;
        if (filt_o[1] !== 1'b1) begin n_errors++; $display("FAIL cke_resume2 got=%b exp=1", filt_o[1]); end
        step();
        n_checks++;
        if (src_o[1] !== 1'b1) begin n_errors++; $display("FAIL cke_resume_src got=%b exp=1", src_o[1]); end
        // Reset with clock enable low, partway through a second source's count.
        irq = 8'h0A;
        step(); step(); step();
        cke = 1'b0; rst_n = 1'b0;
        step();
        n_checks++;
        if (src_o !== 8'h00 || filt_o !== 8'h00) begin
            n_errors++; $display("FAIL reset_under_cke got=%h/%h exp=00/00", src_o, filt_o);
        end
        rst_n = 1'b1; cke = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            n_checks++;
            if (filt_o !== ((e >= 5) ? 8'h0A : 8'h00)) begin
                n_errors++; $display("FAIL restart_filt edge=%0d got=%h", e, filt_o);
            end
            n_checks++;
            if (src_o !== ((e >= 6) ? 8'h0A : 8'h00)) begin
                n_errors++; $display("FAIL restart_src edge=%0d got=%h", e, src_o);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        el = 8'h0F; en = '1; debounce = 4'd3; irq = '0;
        step(); step();
        irq = 8'hFF;
        for (int e = 1; e <= 5; e++) step();
        step();
        n_checks++;
        if (src_o !== 8'hFF) begin n_errors++; $display("FAIL simul_latency got=%h exp=ff", src_o); end
        step();
        // Edge lanes 0-3 have pulsed; level lanes 4-7 stay asserted.
        n_checks++;
        if (src_o !== 8'hF0) begin n_errors++; $display("FAIL simul_after got=%h exp=f0", src_o); end
    endtask

    task automatic test_random();
        do_reset();
        irq = '0; pol = '0; el = '0; en = '1; debounce = 4'd2;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < int'(SOURCES); k++)
                if ($urandom_range(0, 4) == 0) irq[k] = ~irq[k];
            if ($urandom_range(0, 59) == 0) debounce = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) begin
                el = 8'($urandom); en = 8'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                en = '0; pol = 8'($urandom);
            end
            cke   = ($urandom_range(0, 5) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
            n_checks++;
            if (src_o !== m_src) begin
                n_errors++; $display("FAIL rand_src cyc=%0d got=%h exp=%h", c, src_o, m_src);
            end
            n_checks++;
            if (filt_o !== m_filt) begin
                n_errors++; $display("FAIL rand_filt cyc=%0d got=%h exp=%h", c, filt_o, m_filt);
            end
        end
        rst_n = 1'b1; cke = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < int'(SYNC_STAGES); k++) m_pipe.push_back('0);
        for (int k = 0; k < int'(SOURCES); k++) m_run[k] = 0;
        rst_n = 1'b0; cke = 1'b1; irq = '0; pol = '0; el = '0; en = '1; debounce = '0;
        @(negedge clk);
        test_reset();
        test_level_path();
        test_glitch();
        test_edge_mode();
        test_polarity();
        test_cke_reset();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
